// File: rtl/priority_encoder_rr.sv
// priority_encoder_rr
//   N-to-IDX_W encoder with one registered output stage and valid/ready on
//   both sides. The block accepts one request vector per handshake. The next
//   cycle it presents the winning index and two flags: the vector was all
//   zeros, or more than one bit was set.
//   MODE 0 : fixed priority, the highest set bit wins.
//   MODE 1 : round-robin. The search starts at a rotating pointer, and the
//            pointer moves to one past each winner.
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready = !out_valid || out_ready)
//   in_req   [N-1:0]      request vector, sampled only on accept
//   out_valid / out_ready downstream handshake
//   out_idx  [IDX_W-1:0]  winning index (0 for an all-zero vector)
//   out_zero, out_multi   all-zero / multi-hot flags of the accepted vector
module priority_encoder_rr #(
  parameter int N     = 8,
  parameter int IDX_W = 3,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_zero,
  output logic             out_multi
);

  localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

  // (a + b) mod N, where a and b are both already below N.
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                               input logic [IDX_W-1:0] b);
    logic [IDX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_EXT) s = s - N_EXT;
    return s[IDX_W-1:0];
  endfunction

  // Next pointer after a winner. The wrap point is N-1, not 2^IDX_W-1.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] a);
    return (a == LAST) ? '0 : a + IDX_W'(1);
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic             out_zero_q,  out_zero_d;
  logic             out_multi_q, out_multi_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;

  logic [2*N-1:0]   rot_wide;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] rr_off;
  logic [IDX_W-1:0] fixed_idx;
  logic [IDX_W-1:0] win;
  logic             req_zero;
  logic             req_multi;
  logic             accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Winner selection and flags (combinational, ahead of the output register)
  always_comb begin
    // Rotate the vector so that the pointer position lands at bit 0. The
    // lowest set bit of the rotated vector is then the distance from ptr to
    // the round-robin winner.
    rot_wide = {in_req, in_req} >> ptr_q;
    rot      = rot_wide[N-1:0];
    rr_off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) rr_off = IDX_W'(i);
    end

    fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (in_req[i]) fixed_idx = IDX_W'(i);
    end

    win       = (MODE == 0) ? fixed_idx : mod_add(ptr_q, rr_off);
    req_zero  = (in_req == '0);
    // Clearing the lowest set bit leaves something only if there were two or more.
    req_multi = |(in_req & (in_req - N'(1)));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_zero_d  = out_zero_q;
    out_multi_d = out_multi_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = req_zero ? '0 : win;
      out_zero_d  = req_zero;
      out_multi_d = req_multi;
      if ((MODE != 0) && !req_zero) ptr_d = wrap_inc(win);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_zero_q  <= 1'b0;
      out_multi_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_zero_q  <= out_zero_d;
      out_multi_q <= out_multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_zero  = out_zero_q;
  assign out_multi = out_multi_q;

endmodule
